// File: rtl/dot_prod_sequencer.sv
`default_nettype none
// ============================================================================
// dot_prod_sequencer : loads operand pairs into the dot-product kernel arrays,
//                      runs the kernel and returns result, cycle count, status
// Revision 1.0 - initial release
// ============================================================================
module dot_prod_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [10:0]        cmd_len,
    input  logic signed [63:0] cmd_acc,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [26:0] in_a,
    input  logic signed [26:0] in_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [63:0] res_data,
    output logic [31:0]        res_cycles,
    output logic [1:0]         res_status,
    output logic               busy,
    output logic               k_r_enable,
    output logic [9:0]         k_init_i,
    output logic [63:0]        k_init_acc,
    output logic               k_ctrl,
    output logic               k_we,
    output logic [9:0]         k_addr,
    output logic [26:0]        k_wdata_a,
    output logic [26:0]        k_wdata_b,
    input  logic               k_w_enable,
    input  logic signed [63:0] k_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [10:0] MAX_LEN = 11'd1000;

    state_t      state;
    logic [10:0] len;
    logic [9:0]  idx;
    logic [31:0] cyc;

    // k_init_i doubles as the base address of the loaded window
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign in_ready  = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign k_we      = in_ready && in_valid;
    assign k_addr    = k_we ? (k_init_i + idx) : 10'd0;
    assign k_wdata_a = in_a;
    assign k_wdata_b = in_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= 11'd0;
            idx        <= 10'd0;
            cyc        <= 32'd0;
            k_init_i   <= 10'd0;
            k_init_acc <= 64'd0;
            res_valid  <= 1'b0;
            res_data   <= 64'sd0;
            res_cycles <= 32'd0;
            res_status <= 2'd0;
            k_r_enable <= 1'b1;
            k_ctrl     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len > MAX_LEN) begin
                            res_status <= 2'd1;
                            res_data   <= 64'sd0;
                            res_cycles <= 32'd0;
                            res_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            k_init_i   <= 10'(MAX_LEN - cmd_len);
                            k_init_acc <= cmd_acc;
                            len        <= cmd_len;
                            idx        <= 10'd0;
                            cyc        <= 32'd1;
                            if (cmd_len == 11'd0) begin
                                state      <= S_RUN;
                                k_r_enable <= 1'b0;
                                k_ctrl     <= 1'b0;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        idx <= idx + 10'd1;
                        if ({1'b0, idx} == len - 11'd1) begin
                            state      <= S_RUN;
                            k_r_enable <= 1'b0;
                            k_ctrl     <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (k_w_enable) begin
                        res_data   <= k_result;
                        res_cycles <= cyc;
                        res_status <= 2'd0;
                        res_valid  <= 1'b1;
                        k_r_enable <= 1'b1;
                        k_ctrl     <= 1'b1;
                        state      <= S_DONE;
                    end else if (cyc >= TIMEOUT_CYCLES) begin
                        res_data   <= 64'sd0;
                        res_cycles <= cyc;
                        res_status <= 2'd2;
                        res_valid  <= 1'b1;
                        k_r_enable <= 1'b1;
                        k_ctrl     <= 1'b1;
                        state      <= S_DONE;
                    end else if (cyc != 32'hFFFF_FFFF) begin
                        cyc <= cyc + 32'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_prod_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dot_prod_sequencer : directed + randomized jobs against a kernel model
// Revision 1.0 - initial release
// ============================================================================
module tb_dot_prod_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, cmd_valid, cmd_ready, in_valid, in_ready;
    logic [10:0]        cmd_len;
    logic signed [63:0] cmd_acc;
    logic signed [26:0] in_a, in_b;
    logic               res_valid, res_ready, busy;
    logic signed [63:0] res_data;
    logic [31:0]        res_cycles;
    logic [1:0]         res_status;
    logic               k_r_enable, k_ctrl, k_we, k_w_enable;
    logic [9:0]         k_init_i, k_addr;
    logic [63:0]        k_init_acc;
    logic [26:0]        k_wdata_a, k_wdata_b;
    logic signed [63:0] k_result;

    // second instance with a short timeout and a kernel that never finishes
    logic               t_cmd_valid, t_cmd_ready, t_in_valid, t_in_ready;
    logic               t_res_valid, t_res_ready, t_busy;
    logic signed [63:0] t_res_data;
    logic [31:0]        t_res_cycles;
    logic [1:0]         t_res_status;
    logic               t_k_r_enable, t_k_ctrl, t_k_we;
    logic [9:0]         t_k_init_i, t_k_addr;
    logic [63:0]        t_k_init_acc;
    logic [26:0]        t_k_wdata_a, t_k_wdata_b;

    dot_prod_sequencer u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_acc(cmd_acc), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cycles(res_cycles), .res_status(res_status),
        .busy(busy), .k_r_enable(k_r_enable), .k_init_i(k_init_i),
        .k_init_acc(k_init_acc), .k_ctrl(k_ctrl), .k_we(k_we), .k_addr(k_addr),
        .k_wdata_a(k_wdata_a), .k_wdata_b(k_wdata_b), .k_w_enable(k_w_enable),
        .k_result(k_result)
    );

    dot_prod_sequencer #(.TIMEOUT_CYCLES(20)) u_dut_to (
        .clk(clk), .rst(rst), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_len(cmd_len), .cmd_acc(cmd_acc), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_a(in_a), .in_b(in_b), .res_valid(t_res_valid), .res_ready(t_res_ready),
        .res_data(t_res_data), .res_cycles(t_res_cycles), .res_status(t_res_status),
        .busy(t_busy), .k_r_enable(t_k_r_enable), .k_init_i(t_k_init_i),
        .k_init_acc(t_k_init_acc), .k_ctrl(t_k_ctrl), .k_we(t_k_we), .k_addr(t_k_addr),
        .k_wdata_a(t_k_wdata_a), .k_wdata_b(t_k_wdata_b), .k_w_enable(1'b0),
        .k_result(64'sd0)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Kernel model: arrays written through the control port; once released it
    // returns init_acc + sum(a[i]*b[i], i = init_i..999) after (1000-init_i)+4 cycles.
    logic signed [26:0] mem_a [1000];
    logic signed [26:0] mem_b [1000];
    int                 kcnt = 0;
    logic               kw   = 1'b0;
    logic signed [63:0] kres = 64'sd0;
    logic [9:0]         wq_addr [$];
    logic [26:0]        wq_a [$];
    logic [26:0]        wq_b [$];
    int                 both_cnt = 0;

    assign k_w_enable = kw;
    assign k_result   = kres;

    function automatic longint kdot(input int from, input longint acc);
        longint s = acc;
        for (int i = from; i < 1000; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (k_we === 1'b1) begin
            mem_a[k_addr] <= k_wdata_a;
            mem_b[k_addr] <= k_wdata_b;
            wq_addr.push_back(k_addr);
            wq_a.push_back(k_wdata_a);
            wq_b.push_back(k_wdata_b);
        end
        if (k_r_enable !== 1'b0) begin
            kcnt <= 0;
            kw   <= 1'b0;
        end else if (!kw) begin
            if (kcnt == 0) kres <= kdot(int'(k_init_i), longint'(k_init_acc));
            kcnt <= kcnt + 1;
            if (kcnt + 1 == 1000 - int'(k_init_i) + 4) kw <= 1'b1;
        end
    end

    always @(negedge clk) if (cmd_ready === 1'b1 && in_ready === 1'b1) both_cnt++;

    logic signed [26:0] pa [$];
    logic signed [26:0] pb [$];

    task automatic check_reset_values(input string tag);
        check({tag, ".cmd_ready"},  cmd_ready,  1'b0);
        check({tag, ".in_ready"},   in_ready,   1'b0);
        check({tag, ".res_valid"},  res_valid,  1'b0);
        check({tag, ".res_data"},   res_data,   64'd0);
        check({tag, ".res_cycles"}, res_cycles, 64'd0);
        check({tag, ".res_status"}, res_status, 64'd0);
        check({tag, ".busy"},       busy,       1'b0);
        check({tag, ".k_r_enable"}, k_r_enable, 1'b1);
        check({tag, ".k_ctrl"},     k_ctrl,     1'b1);
        check({tag, ".k_we"},       k_we,       1'b0);
        check({tag, ".k_addr"},     k_addr,     64'd0);
        check({tag, ".k_init_i"},   k_init_i,   64'd0);
        check({tag, ".k_init_acc"}, k_init_acc, 64'd0);
    endtask

    // Runs one job on the main instance using pairs in pa/pb; called at a negedge.
    task automatic run_job(input string tag, input int len, input longint acc,
                           input int gap, input int hold);
        longint exp_d;
        int     base, runc, waitc, i, guard, err, nexp, exp_st, exp_cy;
        exp_d = acc;
        for (int k = 0; k < pa.size(); k++) exp_d += longint'(pa[k]) * longint'(pb[k]);
        base   = 1000 - len;
        nexp   = (len > 1000) ? 0 : len;
        exp_st = (len > 1000) ? 1 : 0;
        exp_cy = (len > 1000) ? 0 : len + 5;
        if (len > 1000) exp_d = 0;
        wq_addr.delete(); wq_a.delete(); wq_b.delete();
        cmd_valid = 1'b1;
        cmd_len   = 11'(len);
        cmd_acc   = acc;
        check({tag, ".cmd_ready"}, cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (len <= 1000) begin
            check({tag, ".k_init_i"},   k_init_i,   64'(base));
            check({tag, ".k_init_acc"}, k_init_acc, acc);
        end
        i = 0; guard = 0;
        while (len <= 1000 && i < len && guard < 20000) begin
            in_valid = ($urandom_range(0, 99) >= gap);
            in_a = pa[i];
            in_b = pb[i];
            @(negedge clk);
            if (in_valid) i++;
            guard++;
        end
        in_valid = 1'b0;
        waitc = 0; runc = 0;
        while (!res_valid && waitc < 5000) begin
            if (k_r_enable === 1'b0) runc++;
            @(negedge clk);
            waitc++;
        end
        check({tag, ".res_valid"},  res_valid,  1'b1);
        check({tag, ".res_status"}, res_status, 64'(exp_st));
        check({tag, ".res_data"},   res_data,   exp_d);
        check({tag, ".res_cycles"}, res_cycles, 64'(exp_cy));
        check({tag, ".run_cycles"}, 64'(runc),  64'(exp_cy));
        err = 0;
        for (int k = 0; k < wq_addr.size() && k < nexp; k++)
            if (wq_addr[k] != 10'(base + k) || wq_a[k] != pa[k] || wq_b[k] != pb[k]) err++;
        check({tag, ".n_writes"},    64'(wq_addr.size()), 64'(nexp));
        check({tag, ".write_order"}, 64'(err), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_data"},   res_data,   exp_d);
            check({tag, ".hold_cycles"}, res_cycles, 64'(exp_cy));
            check({tag, ".hold_valid"},  res_valid,  1'b1);
            check({tag, ".hold_cmdrdy"}, cmd_ready,  1'b0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, ".idle_busy"}, busy,      1'b0);
        check({tag, ".idle_rv"},   res_valid, 1'b0);
        check({tag, ".idle_kre"},  k_r_enable, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int runc, waitc, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_acc = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        t_cmd_valid = 1'b0; t_in_valid = 1'b0; t_res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        #1;
        check("post_reset.cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);

        // minimal job
        pa = '{27'sd1, 27'sd3, 27'sd5};
        pb = '{27'sd2, 27'sd4, 27'sd6};
        run_job("minimal", 3, 64'sd10, 0, 0);
        check("minimal.addr_997", wq_addr.size() > 0 ? wq_addr[0] : 10'd0, 64'd997);
        check("minimal.expected_54", res_data, 64'sd54);

        // empty job
        pa.delete(); pb.delete();
        run_job("empty", 0, -64'sd7, 0, 0);

        // full array with stalls
        pa.delete(); pb.delete();
        for (int k = 0; k < 1000; k++) begin pa.push_back(-27'sd1); pb.push_back(-27'sd1); end
        run_job("full", 1000, 64'sd0, 40, 0);

        // bad length
        pa.delete(); pb.delete();
        run_job("badlen", 1001, 64'sd99, 0, 0);

        // randomized jobs
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 40);
            pa.delete(); pb.delete();
            for (int k = 0; k < n; k++) begin
                pa.push_back(27'($urandom));
                pb.push_back(27'($urandom));
            end
            run_job($sformatf("rand%0d", j), n, {$urandom, $urandom}, 25, 0);
        end

        // reset during LOAD at beat 2 of 5
        cmd_valid = 1'b1; cmd_len = 11'd5; cmd_acc = 64'sd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_a = 27'sd100; in_b = 27'sd100;
        @(negedge clk);
        in_a = 27'sd200;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        rst = 1'b0;
        #1;
        check("midreset.cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        pa = '{-27'sd12, 27'sd7};
        pb = '{27'sd5, -27'sd9};
        run_job("after_reset", 2, -64'sd1, 10, 10);

        // timeout on the short-timeout instance
        cmd_len = 11'd2; cmd_acc = 64'sd5;
        t_cmd_valid = 1'b1;
        @(negedge clk);
        t_cmd_valid = 1'b0;
        t_in_valid = 1'b1;
        repeat (2) @(negedge clk);
        t_in_valid = 1'b0;
        waitc = 0; runc = 0;
        while (!t_res_valid && waitc < 200) begin
            if (t_k_r_enable === 1'b0) runc++;
            @(negedge clk);
            waitc++;
        end
        check("timeout.res_valid",  t_res_valid,  1'b1);
        check("timeout.res_status", t_res_status, 64'd2);
        check("timeout.res_data",   t_res_data,   64'd0);
        check("timeout.res_cycles", t_res_cycles, 64'd20);
        check("timeout.run_cycles", 64'(runc),    64'd20);
        t_res_ready = 1'b1;
        @(negedge clk);
        t_res_ready = 1'b0;
        check("timeout.idle_busy", t_busy, 1'b0);

        check("cmd_in_exclusive", 64'(both_cnt), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dot_prod_sequencer.md
# dot_prod_sequencer

Host-side controller for the generated dot-product kernel (`main`) and its two 1000×27-bit operand arrays. It accepts a job command and a stream of (a, b) operand pairs, and loads them into the arrays through the kernel's control port. It then releases the kernel, waits for completion and returns the 64-bit result with a cycle count and status. It sits between the host streaming fabric and one kernel instance, and is the only driver of that kernel's control and start ports.

## Interface
- `TIMEOUT_CYCLES`, 65535: maximum RUN cycles before the job is aborted; range 1..2^32-1.
- `clk` in 1: single clock for the block and the kernel.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: job command handshake.
- `cmd_len` in 11: pair count N; legal range 0..1000.
- `cmd_acc` in 64 signed: initial accumulator value.
- `in_valid` in 1 / `in_ready` out 1: operand-pair handshake.
- `in_a`, `in_b` in 27 signed: one operand pair per beat.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_data` out 64 signed: dot product plus `cmd_acc`.
- `res_cycles` out 32: RUN-state cycle count.
- `res_status` out 2: 0 = ok, 1 = bad length, 2 = timeout.
- `busy` out 1: high in every state except IDLE.
- `k_r_enable` out 1: kernel start/reset line.
- `k_init_i` out 10: kernel loop start index.
- `k_init_acc` out 64: kernel initial accumulator.
- `k_ctrl` out 1: drives `controlArr`.
- `k_we` out 1: drives both `controlArrWEnable_a` and `controlArrWEnable_b`.
- `k_addr` out 10: drives both `controlArrAddr_a` and `controlArrAddr_b`.
- `k_wdata_a`, `k_wdata_b` out 27: drive the control-port write data.
- `k_w_enable` in 1: kernel done flag.
- `k_result` in 64 signed: kernel result.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid` with N > 1000: latch `res_status` = 1, `res_data` = 0, `res_cycles` = 0, go to DONE. No array writes; the kernel is not run.
  - Otherwise latch `base` = 1000 − N into `k_init_i`, latch `cmd_acc` into `k_init_acc`, clear `idx`. Go to LOAD if N > 0, else go to RUN.
- **LOAD**
  - `in_ready` = 1 and `k_ctrl` = 1.
  - On `in_valid`: `k_we` = 1, `k_addr` = `base` + `idx`, `k_wdata_a` = `in_a`, `k_wdata_b` = `in_b`, all combinational in the same cycle. `idx` increments.
  - The beat with `idx` = N−1 moves the block to RUN.
  - Stalls (`in_valid` = 0) are allowed indefinitely.
  - Pairs land at ascending addresses `base`..999, which is the range the kernel walks from `init_i` to 1000.
- **RUN**
  - `k_r_enable` = 0, `k_ctrl` = 0, `k_we` = 0.
  - `cyc` increments every RUN cycle, starting at 1 in the first RUN cycle.
  - In the first cycle with `k_w_enable` = 1: `res_data` ← `k_result`, `res_cycles` ← `cyc`, `res_status` = 0, go to DONE.
  - If `cyc` reaches `TIMEOUT_CYCLES` without `k_w_enable`: `res_data` = 0, `res_status` = 2, go to DONE.
- **DONE**
  - `res_valid` = 1; outputs are held stable until `res_ready`, then go to IDLE.
- **Kernel control outside RUN:** `k_r_enable` = 1 in every state other than RUN, so the kernel sits in its start state with `w_enable` = 0 whenever it is not running. `k_ctrl` = 1 outside RUN.
- **Widths:** address arithmetic is 10-bit unsigned with no wrap, because N ≤ 1000 is guaranteed. `cyc` saturates at its width and never wraps.
- **Array contents** persist between jobs. They are not cleared by the sequencer or by `rst`.

## Timing
- **Reset values** (effective the cycle after `rst` is sampled high):
  - state = IDLE; `cmd_ready` = 0 while `rst` is high.
  - `in_ready` = 0, `res_valid` = 0, `res_data` = 0, `res_cycles` = 0, `res_status` = 0, `busy` = 0.
  - `k_r_enable` = 1, `k_ctrl` = 1, `k_we` = 0, `k_addr` = 0, `k_init_i` = 0, `k_init_acc` = 0.
- **Reset mid-job** (LOAD, RUN or DONE): abandons the job, discards any partial result and returns to IDLE. The kernel is re-held by `k_r_enable`.
- **Command latency:** a command accepted at edge t puts the block in LOAD or RUN at t+1.
- **Load rate:** one pair per cycle maximum.
- **RUN entry:** RUN begins the cycle after the final LOAD beat. `k_init_*` are stable for at least one cycle while `k_r_enable` = 1 before it drops.
- **Handshake simultaneity:**
  - `cmd_ready` and `in_ready` are never both high.
  - `res_valid` with `res_ready` in DONE: IDLE next cycle. A new command is accepted no earlier than the following cycle.
- **`k_w_enable` persistence:** it is sampled only in RUN. A high level left over from a previous job is impossible, because `k_r_enable` = 1 clears it before RUN.

## Test plan
- **Minimal job:** N = 3, pairs (1,2), (3,4), (5,6), `cmd_acc` = 10 → writes at addresses 997, 998, 999; `k_init_i` = 997; `res_data` = 54, `res_status` = 0.
- **Empty job:** N = 0, `cmd_acc` = −7 → no `k_we` pulses; `res_data` = −7, `res_cycles` = 5, `res_status` = 0.
- **Full array with stalls:** N = 1000, a = b = −1 for every pair, random `in_valid` gaps → addresses 0..999 written exactly once; `res_data` = 1000.
- **Bad length:** `cmd_len` = 1001 → DONE next cycle with `res_status` = 1, `res_data` = 0; no array writes; `k_r_enable` stays 1.
- **Timeout:** bench forces `k_w_enable` = 0 with `TIMEOUT_CYCLES` = 20 → `res_status` = 2 after exactly 20 RUN cycles.
- **Reset and back-pressure:** `rst` during LOAD at beat 2 of 5 → IDLE next cycle with all reset values, and a subsequent N = 2 job completes correctly. Then hold `res_ready` = 0 for 10 cycles → result fields stay stable and `cmd_ready` stays 0.
